// File: rtl/rule3_stim_gen_if.sv
// Command and event bundle between a rule3 stimulus generator and whatever drives it.
// The generator takes the slave side; the command issuer takes the master side.
interface rule3_stim_gen_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic [GAP_W-1:0] gap;
    logic             inject_err;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] events_sent;

    modport master (
        output start, burst_len, gap, inject_err,
        input  a, b, c, busy, done, events_sent
    );

    modport slave (
        input  start, burst_len, gap, inject_err,
        output a, b, c, busy, done, events_sent
    );
endinterface

// File: rtl/rule3_stim_gen.sv
// Burst generator for the "a |-> b ##1 c" handshake: a/b strobes separated by a
// programmable gap, c one cycle after each a, optionally dropping the final c.
module rule3_stim_gen #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    rule3_stim_gen_if.slave stim
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic             inj_reg, inj_next;
    logic [GAP_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] sent_reg, sent_next;
    logic             a_reg, b_reg, c_reg, busy_reg, done_reg;
    logic             c_next;
    logic             last_event;

    // sent_reg already counts the event being fired, so equality marks the last one.
    assign last_event = (sent_reg == len_reg);

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        gap_next   = gap_reg;
        inj_next   = inj_reg;
        cnt_next   = cnt_reg;
        sent_next  = sent_reg;

        case (state_reg)
            IDLE: begin
                if (stim.start) begin
                    len_next  = stim.burst_len;
                    gap_next  = stim.gap;
                    inj_next  = stim.inject_err;
                    sent_next = '0;
                    if (stim.burst_len == '0) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = FIRE;
                    end
                end
            end
            FIRE: begin
                if (last_event) begin
                    state_next = DRAIN;
                end else if (gap_reg == '0) begin
                    state_next = FIRE;
                end else begin
                    state_next = WAIT;
                    cnt_next   = gap_reg;
                end
            end
            WAIT: begin
                if (cnt_reg == GAP_W'(1)) begin
                    state_next = FIRE;
                end else begin
                    cnt_next = cnt_reg - GAP_W'(1);
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Count on entry so events_sent moves in the same cycle as the a it describes.
        if (state_next == FIRE) begin
            sent_next = sent_next + CNT_W'(1);
        end
    end

    // c echoes the a currently on the wire, unless it is the poisoned final event.
    assign c_next = (state_reg == FIRE) && !(inj_reg && last_event);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            gap_reg   <= '0;
            inj_reg   <= 1'b0;
            cnt_reg   <= '0;
            sent_reg  <= '0;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            c_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            gap_reg   <= gap_next;
            inj_reg   <= inj_next;
            cnt_reg   <= cnt_next;
            sent_reg  <= sent_next;
            a_reg     <= (state_next == FIRE);
            b_reg     <= (state_next == FIRE);
            c_reg     <= c_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == DRAIN);
        end
    end

    assign stim.a           = a_reg;
    assign stim.b           = b_reg;
    assign stim.c           = c_reg;
    assign stim.busy        = busy_reg;
    assign stim.done        = done_reg;
    assign stim.events_sent = sent_reg;

endmodule

// File: doc/rule3_stim_gen.md
Name: rule3_stim_gen

Overview:
- Stimulus generator and driver side of the "a |-> b ##1 c" handshake that our concurrent property checks in monitor modules.
- On a start command it emits a programmable burst of a/b events, each followed one cycle later by c, with a programmable idle gap between events.
- It can deliberately drop the final c, so benches can exercise both the pass and the fail paths of the property.
- It sits in the testbench or stimulus layer, in front of any module that carries the rule3-style assertion.

Parameters:
- CNT_W, 8, width of burst_len and events_sent.
- GAP_W, 4, width of gap.

Ports:
- clk  input  1  single clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; accepted only in IDLE.
- burst_len  input  CNT_W  number of a-events in the burst; sampled on accepted start.
- gap  input  GAP_W  idle cycles between consecutive a-events; sampled on accepted start.
- inject_err  input  1  suppress c for the last event of the burst; sampled on accepted start.
- a  output  1  antecedent strobe.
- b  output  1  same-cycle consequent.
- c  output  1  next-cycle consequent.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse in the DRAIN cycle.
- events_sent  output  CNT_W  a-events issued in the current or most recent burst.

Behaviour:
- Reset:
  - At the first posedge with rst=1: a=b=c=busy=done=0, events_sent=0, state=IDLE, internal c-pending flag cleared.
  - Reset mid-burst aborts the burst immediately; no trailing c is emitted.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: outputs low. start=1 latches burst_len/gap/inject_err and clears events_sent.
    - burst_len=0 -> DRAIN.
    - Otherwise -> FIRE.
  - FIRE: a=b=1 for exactly one cycle; events_sent increments.
    - If this is the last event -> DRAIN.
    - Else if gap=0 -> FIRE (back-to-back).
    - Else -> WAIT with the gap counter loaded to gap.
  - WAIT: a=b=0; the counter decrements each cycle; -> FIRE after exactly gap cycles.
  - DRAIN: one cycle, done=1, a=b=0 -> IDLE.
- c rule: c(t+1) = a(t), except when inject_err is latched and a(t) was the last event, in which case c(t+1)=0.
  - c may coincide with a new a (gap=0 overlap); this is legal and required.
- Latency: start in IDLE at cycle T -> first a at T+1. Event period = gap+1 cycles.
- Burst length: last a at T+1+(burst_len-1)(gap+1); DRAIN (done, final c) is the next cycle.
- busy: high from T+1 through the DRAIN cycle inclusive.
- start while busy: ignored, with no effect on latched values; the next start is accepted in IDLE at the earliest.
- events_sent: holds its final value after DRAIN until the next accepted start; never exceeds burst_len.
- b is never asserted without a; c is never asserted without a in the previous cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> a=b=c=busy=done=0, events_sent=0.
- Back-to-back: start at T, burst_len=3, gap=0, inject_err=0 ->
  - a=b=1 at T+1..T+3; c=1 at T+2..T+4.
  - done=1 only at T+4; busy T+1..T+4; events_sent=3.
  - Property a |-> b ##1 c passes.
- Gapped: burst_len=2, gap=2, start at T ->
  - a at T+1 and T+4; c at T+2 and T+5.
  - done at T+5; a=b=c=0 at T+3.
- Error injection: burst_len=2, gap=0, inject_err=1, start at T ->
  - a at T+1, T+2; c=1 at T+2, c=0 at T+3.
  - Exactly one property failure is reported (for a at T+2); done at T+3.
- Zero length and start-while-busy:
  - burst_len=0 -> busy=done=1 at T+1 only, no a; events_sent=0.
  - Separately, a second start during a burst_len=4 burst changes nothing: events_sent ends at 4.
- Reset mid-burst: rst asserted at T+2 of a burst_len=5, gap=0 run ->
  - All outputs 0 from the following edge; no c at T+3.
  - A new start after reset runs normally.
